cell_sweep_ctrl: RTL and testbench
==================================

Name: cell_sweep_ctrl

Overview:
Self-checking stimulus sequencer for single-output combinational standard cells (AOI/OAI family, e.g. a 5-input AOI221-class cell).
- On start, drives every input combination of the cell under test in ascending binary order.
- Waits a programmable settle time per vector, then samples the cell output and compares it against a golden truth table.
- Streams one result per vector and reports pass/fail, error count and first failing vector.
- Replaces hand-written exhaustive stimulus blocks in cell-level benches and in on-chip cell characterisation wrappers.

Parameters:
N_IN, 5, number of cell inputs; sweep covers 2^N_IN vectors.
SETTLE, 10, clock cycles the output settles before sampling; legal range 1..255.
GOLDEN, 32'h0000_0777, expected output per vector; bit k = expected output for vector k; width 2^N_IN. Default is ZN = !(A | B1&B2 | C1&C2).

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  reset, synchronous, active-low.
start  in  1  begin sweep; sampled in IDLE or DONE only.
abort  in  1  stop sweep, return to IDLE.
dut_out  in  1  cell output under test.
dut_in  out  N_IN  cell input vector; bit N_IN-1 is the first-listed pin (A), bit 0 the last (C2).
busy  out  1  sweep in progress.
done  out  1  sweep complete; held until next start or reset.
pass  out  1  valid when done; 1 = zero mismatches.
err_count  out  N_IN+1  number of mismatching vectors.
first_fail  out  N_IN  lowest mismatching vector.
first_fail_vld  out  1  first_fail holds a valid vector.
res_valid  out  1  one-cycle pulse per sampled vector.
res_vec  out  N_IN  vector just sampled.
res_out  out  1  sampled dut_out.
res_ok  out  1  1 = sampled value matched GOLDEN.

Behaviour:
- Reset (rst_n=0 at a rising edge): all outputs 0, state IDLE, counters 0. Takes priority over every other input, including mid-sweep. No partial results are kept.
- States: IDLE, SETTLE, SAMPLE, DONE.
- Start acceptance:
  - IDLE/DONE & start=1 at edge e0: dut_in<=0, err_count<=0, first_fail_vld<=0, first_fail<=0, done<=0, pass<=0, busy<=1, settle counter<=SETTLE-1, next state SETTLE.
  - start while busy: ignored.
- SETTLE: counter decrements each edge; at 0, next state SAMPLE.
- SAMPLE edge:
  - Compare dut_out with GOLDEN[dut_in]. A non-0/1 dut_out is a mismatch (4-state comparison in simulation).
  - Outputs for that cycle: res_valid=1, res_vec=dut_in, res_out=dut_out, res_ok=match.
  - On mismatch: err_count+1. If first_fail_vld=0, set first_fail=dut_in and first_fail_vld=1.
  - If dut_in is not all-ones: dut_in<=dut_in+1, counter reload, next state SETTLE.
  - If dut_in is all-ones: next state DONE; busy<=0, done<=1, pass<=(final err_count==0). Pass includes the last vector's result.
  - dut_in is not wrapped back to 0; it holds all-ones in DONE.
- Timing:
  - Each vector is held for exactly SETTLE+1 cycles.
  - Vector k is applied at edge e0+k*(SETTLE+1).
  - res_valid for vector k is asserted in the cycle ending at edge e0+(k+1)*(SETTLE+1).
  - done rises at edge e0+2^N_IN*(SETTLE+1). Defaults: e0+352.
- err_count width N_IN+1: holds 2^N_IN without saturation.
- abort=1 (not in reset):
  - From SETTLE/SAMPLE: next state IDLE, busy<=0, done stays 0, dut_in<=0; no res_valid that edge; err_count and first_fail retain their partial values.
  - From IDLE/DONE: no effect.
  - abort and start at the same edge: abort wins.
- res_valid is 0 in every state other than SAMPLE.

Test Plan:
- Good AOI221 model, defaults: start at e0 -> 32 res_valid pulses, res_vec 0..31 in order, res_ok all 1; done at e0+352, pass=1, err_count=0, first_fail_vld=0.
- dut_out stuck-at-0: mismatches on vectors 0-2, 4-6, 8-10 -> err_count=9, first_fail=0, first_fail_vld=1, pass=0.
- Model inverting output only for vector 13 -> err_count=1, first_fail=13, all other res_ok=1.
- SETTLE=1: dut_in changes every 2 cycles -> done at e0+64; with a 3-cycle-delayed model, mismatches are flagged on output transitions.
- abort asserted at edge e0+50 -> busy=0, dut_in=0, done=0, no further res_valid; new start then gives a full clean sweep with err_count reset.
- rst_n low for one edge mid-sweep (e0+100) -> all outputs 0 at next cycle; start while busy is ignored (res_vec sequence unbroken); restart from DONE re-sweeps.

Source files
------------

// File: rtl/cell_sweep_ctrl_if.sv
// rtl/cell_sweep_ctrl_if.sv - control, cell drive and result signals of the cell sweep sequencer
interface cell_sweep_ctrl_if #(
  parameter int N_IN = 5
);
  logic            start;
  logic            abort;
  logic            dut_out;
  logic [N_IN-1:0] dut_in;
  logic            busy;
  logic            done;
  logic            pass;
  logic [N_IN:0]   err_count;
  logic [N_IN-1:0] first_fail;
  logic            first_fail_vld;
  logic            res_valid;
  logic [N_IN-1:0] res_vec;
  logic            res_out;
  logic            res_ok;

  // Bench / wrapper side: issues commands, models the cell, observes results.
  modport master (
    output start, abort, dut_out,
    input  dut_in, busy, done, pass, err_count, first_fail, first_fail_vld,
    input  res_valid, res_vec, res_out, res_ok
  );

  // Sequencer side.
  modport slave (
    input  start, abort, dut_out,
    output dut_in, busy, done, pass, err_count, first_fail, first_fail_vld,
    output res_valid, res_vec, res_out, res_ok
  );
endinterface

// File: rtl/cell_sweep_ctrl.sv
// rtl/cell_sweep_ctrl.sv - exhaustive stimulus sequencer and golden checker for a combinational cell
module cell_sweep_ctrl #(
  parameter int                      N_IN   = 5,
  parameter int                      SETTLE = 10,
  parameter logic [(2**N_IN)-1:0]    GOLDEN = 32'h0000_0777
) (
  input logic              clk,
  input logic              rst_n,
  cell_sweep_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_SAMPLE,
    S_DONE
  } state_t;

  // Counter runs SETTLE-1 down to 0, then one SAMPLE cycle: SETTLE+1 cycles per vector.
  localparam logic [7:0] SETTLE_LD = 8'(SETTLE - 1);

  state_t          state, state_nx;
  logic [7:0]      cnt, cnt_nx;
  logic [N_IN-1:0] vec, vec_nx;
  logic            busy_r, busy_nx;
  logic            done_r, done_nx;
  logic            pass_r, pass_nx;
  logic [N_IN:0]   err_r, err_nx;
  logic [N_IN:0]   err_inc;
  logic [N_IN-1:0] ff_r, ff_nx;
  logic            ffv_r, ffv_nx;
  logic            gold_bit;
  logic            match;
  logic            sample_fire;

  // Golden comparison and next-state / next-register computation.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    vec_nx   = vec;
    busy_nx  = busy_r;
    done_nx  = done_r;
    pass_nx  = pass_r;
    err_nx   = err_r;
    ff_nx    = ff_r;
    ffv_nx   = ffv_r;

    gold_bit    = GOLDEN[vec];
    // Case equality so an X/Z cell output counts as a mismatch in simulation.
    match       = (bus.dut_out === gold_bit);
    sample_fire = (state == S_SAMPLE) && !bus.abort;
    err_inc     = err_r + {{N_IN{1'b0}}, ~match};

    case (state)
      S_IDLE, S_DONE: begin
        // abort wins over a simultaneous start
        if (bus.start && !bus.abort) begin
          vec_nx   = '0;
          err_nx   = '0;
          ffv_nx   = 1'b0;
          ff_nx    = '0;
          done_nx  = 1'b0;
          pass_nx  = 1'b0;
          busy_nx  = 1'b1;
          cnt_nx   = SETTLE_LD;
          state_nx = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (bus.abort) begin
          state_nx = S_IDLE;
          busy_nx  = 1'b0;
          vec_nx   = '0;
        end else if (cnt == 8'd0) begin
          state_nx = S_SAMPLE;
        end else begin
          cnt_nx = cnt - 8'd1;
        end
      end
      S_SAMPLE: begin
        if (bus.abort) begin
          state_nx = S_IDLE;
          busy_nx  = 1'b0;
          vec_nx   = '0;
        end else begin
          err_nx = err_inc;
          if (!match && !ffv_r) begin
            ff_nx  = vec;
            ffv_nx = 1'b1;
          end
          if (vec != '1) begin
            vec_nx   = vec + 1'b1;
            cnt_nx   = SETTLE_LD;
            state_nx = S_SETTLE;
          end else begin
            // last vector: verdict includes this sample's result
            state_nx = S_DONE;
            busy_nx  = 1'b0;
            done_nx  = 1'b1;
            pass_nx  = (err_inc == '0);
          end
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // State and result registers; reset discards any partial sweep.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      cnt    <= '0;
      vec    <= '0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      pass_r <= 1'b0;
      err_r  <= '0;
      ff_r   <= '0;
      ffv_r  <= 1'b0;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      vec    <= vec_nx;
      busy_r <= busy_nx;
      done_r <= done_nx;
      pass_r <= pass_nx;
      err_r  <= err_nx;
      ff_r   <= ff_nx;
      ffv_r  <= ffv_nx;
    end
  end

  assign bus.dut_in         = vec;
  assign bus.busy           = busy_r;
  assign bus.done           = done_r;
  assign bus.pass           = pass_r;
  assign bus.err_count      = err_r;
  assign bus.first_fail     = ff_r;
  assign bus.first_fail_vld = ffv_r;
  assign bus.res_valid      = sample_fire;
  assign bus.res_vec        = sample_fire ? vec : '0;
  assign bus.res_out        = sample_fire ? bus.dut_out : 1'b0;
  assign bus.res_ok         = sample_fire & match;

endmodule

// File: tb/tb_cell_sweep_ctrl.sv
// tb/tb_cell_sweep_ctrl.sv - scoreboard bench for cell_sweep_ctrl with AOI221 cell models
module tb_cell_sweep_ctrl;

  localparam int N  = 5;
  localparam int NV = 32;
  localparam int SA = 10;
  localparam int SB = 1;

  typedef struct {
    logic [N-1:0] vec;
    logic         out;
    logic         ok;
    int           edge_no;
  } res_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  res_t qa[$];
  res_t qb[$];

  logic [31:0]  fault_mask = 32'h0;
  logic [N-1:0] d1 = '0, d2 = '0, d3 = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cell_sweep_ctrl_if #(.N_IN(N)) ia ();
  cell_sweep_ctrl_if #(.N_IN(N)) ib ();

  cell_sweep_ctrl #(.N_IN(N), .SETTLE(SA)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ia.slave));
  cell_sweep_ctrl #(.N_IN(N), .SETTLE(SB)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ib.slave));

  // Reference cell: ZN = !(A | B1&B2 | C1&C2), A = bit 4 ... C2 = bit 0.
  function automatic logic aoi221(input logic [N-1:0] v);
    return !(v[4] | (v[3] & v[2]) | (v[1] & v[0]));
  endfunction

  // Cell A: good AOI221 with per-vector output inversions from fault_mask.
  assign ia.dut_out = aoi221(ia.dut_in) ^ fault_mask[ia.dut_in];

  // Cell B: good AOI221 whose output lags its inputs by three clocks.
  always @(posedge clk) begin
    d1 <= ib.dut_in;
    d2 <= d1;
    d3 <= d2;
  end
  assign ib.dut_out = aoi221(d3);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic compare_res(input string tag, input res_t e, input logic [N-1:0] vec,
                             input logic out, input logic ok);
    check({tag, "_res_vec"}, 32'(vec), 32'(e.vec));
    check({tag, "_res_out"}, 32'(out), 32'(e.out));
    check({tag, "_res_ok"}, 32'(ok), 32'(e.ok));
    check({tag, "_res_edge"}, 32'(cyc + 1), 32'(e.edge_no));
  endtask

  // Monitors: pop one expected result per res_valid pulse.
  always @(negedge clk) begin
    if (ia.res_valid) begin
      if (qa.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL a_unexpected_res: got vec %0d expected no result", ia.res_vec);
      end else begin
        compare_res("a", qa.pop_front(), ia.res_vec, ia.res_out, ia.res_ok);
      end
    end
  end

  always @(negedge clk) begin
    if (ib.res_valid) begin
      if (qb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL b_unexpected_res: got vec %0d expected no result", ib.res_vec);
      end else begin
        compare_res("b", qb.pop_front(), ib.res_vec, ib.res_out, ib.res_ok);
      end
    end
  end

  // Expected results of cell A for vectors 0..last, sampled SA+1 cycles apart.
  task automatic push_a(input int e0, input logic [31:0] mask, input int last);
    res_t e;
    for (int k = 0; k <= last; k++) begin
      e.vec     = N'(k);
      e.out     = aoi221(N'(k)) ^ mask[k];
      e.ok      = !mask[k];
      e.edge_no = e0 + (k + 1) * (SA + 1);
      qa.push_back(e);
    end
  endtask

  task automatic start_a(output int e0);
    @(posedge clk);
    #1 ia.start = 1'b1;
    @(posedge clk);
    #1 e0 = cyc;
    ia.start = 1'b0;
  endtask

  // One full sweep of cell A; optionally pokes start while busy.
  task automatic run_a(input logic [31:0] mask, input bit poke);
    int  e0;
    int  first;
    bit  seen;
    fault_mask = mask;
    start_a(e0);
    push_a(e0, mask, NV - 1);
    seen = 0;
    for (int i = 0; i < 1000 && !seen; i++) begin
      @(posedge clk);
      #1;
      ia.start = poke && ia.busy && (((cyc - e0) % 67) == 5);
      if (ia.done) seen = 1;
    end
    ia.start = 1'b0;
    if (!seen) begin
      n_checks++;
      n_fail++;
      $display("FAIL a_done_timeout: got no done expected done by cycle %0d", e0 + 352);
    end
    first = 0;
    for (int k = NV - 1; k >= 0; k--) if (mask[k]) first = k;
    check("a_done_edge", 32'(cyc - e0), 32'(NV * (SA + 1)));
    check("a_busy_done", 32'(ia.busy), 32'd0);
    check("a_pass", 32'(ia.pass), 32'(mask == 32'h0));
    check("a_err_count", 32'(ia.err_count), 32'($countones(mask)));
    check("a_first_fail_vld", 32'(ia.first_fail_vld), 32'(mask != 32'h0));
    check("a_first_fail", 32'(ia.first_fail), 32'(first));
    check("a_dut_in_hold", 32'(ia.dut_in), 32'(NV - 1));
    check("a_queue_drained", 32'(qa.size()), 32'd0);
  endtask

  initial begin
    int e0;
    int trans;
    bit seen;
    res_t e;
    logic [31:0] m;

    ia.start = 1'b0; ia.abort = 1'b0;
    ib.start = 1'b0; ib.abort = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    check("rst_busy", 32'(ia.busy), 32'd0);
    check("rst_done", 32'(ia.done), 32'd0);
    check("rst_pass", 32'(ia.pass), 32'd0);
    check("rst_err", 32'(ia.err_count), 32'd0);
    check("rst_dut_in", 32'(ia.dut_in), 32'd0);
    check("rst_ffv", 32'(ia.first_fail_vld), 32'd0);
    check("rst_res_valid", 32'(ia.res_valid), 32'd0);

    // SETTLE=1 instance with a 3-cycle-late cell: mismatch wherever the output toggles.
    @(posedge clk);
    #1 ib.start = 1'b1;
    @(posedge clk);
    #1 e0 = cyc;
    ib.start = 1'b0;
    trans = 0;
    for (int k = 0; k < NV; k++) begin
      e.vec     = N'(k);
      e.out     = aoi221(N'((k == 0) ? 0 : k - 1));
      e.ok      = (e.out == aoi221(N'(k)));
      e.edge_no = e0 + (k + 1) * (SB + 1);
      if (!e.ok) trans++;
      qb.push_back(e);
    end
    seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(posedge clk);
      #1;
      if (ib.done) seen = 1;
    end
    check("b_done_seen", 32'(seen), 32'd1);
    check("b_done_edge", 32'(cyc - e0), 32'(NV * (SB + 1)));
    check("b_err_count", 32'(ib.err_count), 32'(trans));
    check("b_pass", 32'(ib.pass), 32'(trans == 0));
    check("b_queue_drained", 32'(qb.size()), 32'd0);

    // Directed sweeps on the default instance: good, stuck-at-0, single inversion.
    run_a(32'h0, 1'b0);
    run_a(32'h0000_0777, 1'b0);
    run_a(32'h0000_2000, 1'b0);

    // Abort at e0+50 together with start: partial errors kept, no more results.
    fault_mask = 32'h0010_000A;
    start_a(e0);
    push_a(e0, fault_mask, 3);
    repeat (49) @(posedge clk);
    #1 ia.abort = 1'b1;
    ia.start = 1'b1;
    @(posedge clk);
    #1 ia.abort = 1'b0;
    ia.start = 1'b0;
    check("abort_busy", 32'(ia.busy), 32'd0);
    check("abort_dut_in", 32'(ia.dut_in), 32'd0);
    check("abort_done", 32'(ia.done), 32'd0);
    check("abort_err_count", 32'(ia.err_count), 32'd2);
    check("abort_first_fail", 32'(ia.first_fail), 32'd1);
    check("abort_ffv", 32'(ia.first_fail_vld), 32'd1);
    repeat (60) @(posedge clk);
    #1 check("abort_stays_idle", 32'(ia.busy), 32'd0);
    check("abort_queue_drained", 32'(qa.size()), 32'd0);
    run_a(32'h0, 1'b0);

    // abort + start in DONE: nothing changes.
    @(posedge clk);
    #1 ia.abort = 1'b1;
    ia.start = 1'b1;
    @(posedge clk);
    #1 ia.abort = 1'b0;
    ia.start = 1'b0;
    @(posedge clk);
    #1 check("done_abort_busy", 32'(ia.busy), 32'd0);
    check("done_abort_done", 32'(ia.done), 32'd1);

    // Reset for one edge at e0+100 discards the partial sweep.
    fault_mask = $urandom() | 32'h1;
    start_a(e0);
    push_a(e0, fault_mask, 8);
    repeat (99) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    check("mid_rst_busy", 32'(ia.busy), 32'd0);
    check("mid_rst_done", 32'(ia.done), 32'd0);
    check("mid_rst_err", 32'(ia.err_count), 32'd0);
    check("mid_rst_ffv", 32'(ia.first_fail_vld), 32'd0);
    check("mid_rst_ff", 32'(ia.first_fail), 32'd0);
    check("mid_rst_dut_in", 32'(ia.dut_in), 32'd0);
    check("mid_rst_queue", 32'(qa.size()), 32'd0);

    // start pokes while busy are ignored; restart from DONE re-sweeps.
    run_a(32'h0, 1'b1);
    run_a(32'h8000_0001, 1'b0);

    // Random fault patterns.
    for (int r = 0; r < 3; r++) begin
      m = $urandom();
      run_a(m, r == 1);
    end

    repeat (5) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
